// File: rtl/demux_fifo4.sv
// rtl/demux_fifo4.sv - one-to-four demux feeding independent per-channel FIFOs
// Each channel shows its head word while non-empty, and the last popped word while empty.
module demux_fifo4 #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [1:0] in_sel,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic [7:0] xfer_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [3:0]    mem_q    [4][DEPTH];
  logic [PW-1:0] wr_ptr_q [4];
  logic [PW-1:0] wr_ptr_d [4];
  logic [PW-1:0] rd_ptr_q [4];
  logic [PW-1:0] rd_ptr_d [4];
  logic [CW-1:0] cnt_q    [4];
  logic [CW-1:0] cnt_d    [4];
  logic [3:0]    last_q   [4];
  logic [3:0]    last_d   [4];
  logic [3:0]    head     [4];
  logic [7:0]    xfer_cnt_q;
  logic [7:0]    xfer_cnt_d;
  logic [3:0]    push;
  logic [3:0]    pop;

  // Readiness looks only at the selected channel's current occupancy, never at pops.
  always_comb begin
    in_ready = !rst && (cnt_q[in_sel] != FULL);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (cnt_q[i] != '0);
      head[i]      = out_valid[i] ? mem_q[i][rd_ptr_q[i]] : last_q[i];
      push[i]      = in_valid && in_ready && (in_sel == 2'(i));
      pop[i]       = !rst && out_valid[i] && out_ready[i];
      wr_ptr_d[i]  = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i]  = rd_ptr_q[i] + PW'(pop[i]);
      cnt_d[i]     = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      last_d[i]    = pop[i] ? head[i] : last_q[i];
    end
    xfer_cnt_d = xfer_cnt_q + 8'(|push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        last_q[i]   <= '0;
      end
      xfer_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          mem_q[i][wr_ptr_q[i]] <= in_data;
        end
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
        last_q[i]   <= last_d[i];
      end
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign a        = head[0];
  assign b        = head[1];
  assign c        = head[2];
  assign d        = head[3];
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_demux_fifo4.sv
// tb/tb_demux_fifo4.sv - self-checking bench for demux_fifo4
// Reference model: one queue per channel, last-popped word per channel, modulo-256 transfer count.
module tb_demux_fifo4;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] a, b, c, d;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] xfer_cnt;

  demux_fifo4 #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] mq [4][$];
  logic [3:0] mlast [4];
  int         mcnt = 0;
  logic       rdy_seen;
  logic [3:0] ov_seen;
  logic [3:0] a_seen;
  logic [3:0] dout [4];

  assign dout[0] = a;
  assign dout[1] = b;
  assign dout[2] = c;
  assign dout[3] = d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [1:0] s,
                              input logic [3:0] dt, input logic [3:0] ordy);
    logic push_ok;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        mlast[i] = 4'h0;
      end
      mcnt = 0;
    end else begin
      push_ok = v && (mq[s].size() < DEPTH);
      for (int i = 0; i < 4; i++) begin
        if (ordy[i] && mq[i].size() > 0) mlast[i] = mq[i].pop_front();
      end
      if (push_ok) begin
        mq[s].push_back(dt);
        mcnt = (mcnt + 1) % 256;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
      chk($sformatf("head%0d", i), 32'(dout[i]),
          32'((mq[i].size() > 0) ? mq[i][0] : mlast[i]));
    end
    chk("xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [3:0] dt, input logic [3:0] ordy);
    logic exp_rdy;
    rst = r; in_valid = v; in_sel = s; in_data = dt; out_ready = ordy;
    @(negedge clk);
    exp_rdy  = !r && (mq[s].size() < DEPTH);
    rdy_seen = in_ready;
    ov_seen  = out_valid;
    a_seen   = a;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    model_update(r, v, s, dt, ordy);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] sent [$];
    logic [3:0] got [$];
    logic [3:0] dt;
    logic [3:0] ordy;
    logic       v;
    int         n_sent;

    for (int i = 0; i < 4; i++) mlast[i] = 4'h0;
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'h0; out_ready = 4'h0;

    // reset state
    step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_xfer", 32'(xfer_cnt), 32'h0);
    chk("rst_ready", 32'(rdy_seen), 32'h0);

    // routing
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'(k), 4'(k + 1), 4'h0);
    chk("route_a", 32'(a), 32'h1);
    chk("route_b", 32'(b), 32'h2);
    chk("route_c", 32'(c), 32'h3);
    chk("route_d", 32'(d), 32'h4);
    chk("route_valid", 32'(out_valid), 32'hF);
    chk("route_xfer", 32'(xfer_cnt), 32'h4);

    // full backpressure on b
    step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 2'd1, 4'h5, 4'h0);
    step(1'b0, 1'b1, 2'd1, 4'h6, 4'h0);
    step(1'b0, 1'b1, 2'd1, 4'h7, 4'h0);
    chk("bp_ready_full", 32'(rdy_seen), 32'h0);
    chk("bp_b_head", 32'(b), 32'h5);
    chk("bp_xfer", 32'(xfer_cnt), 32'h2);
    step(1'b0, 1'b1, 2'd1, 4'h7, 4'b0010);
    chk("bp_ready_full_with_pop", 32'(rdy_seen), 32'h0);
    chk("bp_b_after_pop", 32'(b), 32'h6);
    in_valid = 1'b0; in_sel = 2'd1; out_ready = 4'h0;
    #1;
    chk("bp_ready_free", 32'(in_ready), 32'h1);

    // simultaneous push and pop on c
    step(1'b0, 1'b1, 2'd2, 4'h8, 4'h0);
    step(1'b0, 1'b1, 2'd2, 4'h9, 4'b0100);
    chk("pp_c_valid", 32'(out_valid[2]), 32'h1);
    chk("pp_c_head", 32'(c), 32'h9);
    step(1'b0, 1'b0, 2'd2, 4'h0, 4'b0100);
    chk("pp_c_empty", 32'(out_valid[2]), 32'h0);
    chk("pp_c_hold", 32'(c), 32'h9);

    // pointer wrap on a
    step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    n_sent = 0;
    for (int it = 0; it < 400 && got.size() < 20; it++) begin
      v    = (n_sent < 20);
      dt   = 4'($urandom);
      ordy = {3'b000, 1'($urandom)};
      step(1'b0, v, 2'd0, dt, ordy);
      if (v && rdy_seen) begin
        sent.push_back(dt);
        n_sent++;
      end
      if (ov_seen[0] && ordy[0]) got.push_back(a_seen);
    end
    chk("wrap_count", 32'(got.size()), 32'd20);
    for (int k = 0; k < 20 && k < got.size(); k++) chk($sformatf("wrap_word%0d", k), 32'(got[k]), 32'(sent[k]));

    // randomized traffic on all channels
    for (int it = 0; it < 200; it++) begin
      step(1'b0, 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    end

    // counter wrap
    step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    for (int k = 0; k < 256; k++) begin
      step(1'b0, 1'b1, 2'(k % 4), 4'($urandom), 4'hF);
      if (k == 254) chk("cnt_255", 32'(xfer_cnt), 32'd255);
    end
    chk("cnt_wrap", 32'(xfer_cnt), 32'd0);

    // reset mid-operation
    for (int k = 0; k < 4 * DEPTH; k++) step(1'b0, 1'b1, 2'(k % 4), 4'(k + 1), 4'h0);
    chk("mid_full", 32'(out_valid), 32'hF);
    step(1'b1, 1'b1, 2'd0, 4'h3, 4'hF);
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_data", 32'({a, b, c, d}), 32'h0);
    chk("mid_xfer", 32'(xfer_cnt), 32'h0);
    step(1'b0, 1'b1, 2'd3, 4'h5, 4'h0);
    chk("mid_accept", 32'(rdy_seen), 32'h1);
    chk("mid_d", 32'(d), 32'h5);
    chk("mid_xfer1", 32'(xfer_cnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_fifo4.md
DEMUX_FIFO4 -- requirements
Module: demux_fifo4

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the entries per output channel FIFO; legal values are 2, 4, 8 and 16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 in_valid  input  1  SHALL qualify in_data/in_sel.
REQ-005 in_ready  output  1  SHALL indicate the selected channel can accept a word.
REQ-006 in_data  input  4  SHALL carry the payload word.
REQ-007 in_sel  input  2  SHALL select the destination: 00=a, 01=b, 10=c, 11=d.
REQ-008 a, b, c, d  output  4 each  SHALL carry the head word of the channel a/b/c/d FIFO.
REQ-009 out_valid  output  4  SHALL flag a non-empty channel FIFO; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-010 out_ready  input  4  SHALL be the per-channel consumer acceptance, with the same bit mapping as out_valid.
REQ-011 xfer_cnt  output  8  SHALL count accepted input words.

Function
REQ-012 An input transfer SHALL occur on a clock edge where in_valid=1 and in_ready=1; the word is pushed into the FIFO chosen by in_sel.
REQ-013 in_ready SHALL be combinational: 1 when rst=0 and the FIFO selected by the current in_sel is not full, else 0.
REQ-014 in_ready SHALL NOT depend on in_valid or on out_ready (no pass-through when full).
REQ-015 An output transfer on channel i SHALL occur on an edge where out_valid[i]=1 and out_ready[i]=1; it pops that FIFO.
REQ-016 Latency SHALL be exactly one cycle: a word accepted at edge N SHALL drive its channel's output and set out_valid from edge N onward if that FIFO was empty.
REQ-017 Each channel SHALL preserve arrival order; channels SHALL be fully independent and may pop concurrently.
REQ-018 Push and pop of the same channel on the same edge SHALL both take effect; the occupancy is unchanged and the head advances.
REQ-019 A full channel SHALL hold in_ready=0 for that in_sel even when its out_ready=1 in the same cycle.
REQ-020 Per-channel occupancy SHALL range 0..DEPTH; read and write pointers SHALL wrap modulo DEPTH.
REQ-021 out_valid[i] SHALL be 1 if and only if occupancy[i] > 0.
REQ-022 When occupancy[i] = 0, output i SHALL hold the last popped value; after reset that value is 0.
REQ-023 out_ready[i] asserted while out_valid[i]=0 SHALL have no effect.
REQ-024 in_data and in_sel SHALL be ignored when in_valid=0.
REQ-025 xfer_cnt SHALL increment by 1 per input transfer and wrap from 255 to 0.
REQ-026 out_valid and output data SHALL come directly from registers or storage, with no combinational path from inputs.

Reset
REQ-027 While rst=1 at an edge, all occupancies, pointers and xfer_cnt SHALL clear to 0, storage SHALL clear to 0, out_valid SHALL be 4'b0000 and a/b/c/d SHALL be 4'h0.
REQ-028 While rst=1, in_ready SHALL be 0 and no push or pop SHALL occur.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words; the first edge after rst falls SHALL accept input.

Verification
REQ-030 The bench SHALL cover routing:
- Stimulus: after reset, send in_sel=00..11 with data 1,2,3,4 while out_ready=0.
- Response: a=1, b=2, c=3, d=4; out_valid=1111; xfer_cnt=4.
REQ-031 The bench SHALL cover full backpressure:
- Stimulus: DEPTH=2, out_ready=0, send 5,6,7 to channel b.
- Response: in_ready=0 after the second word; b=5; 7 is not accepted.
- Then: out_ready[1]=1 for one cycle gives b=6 and in_ready=1.
REQ-032 The bench SHALL cover simultaneous push and pop:
- Stimulus: channel c holds 1 word; push 9 to c with out_ready[2]=1 on the same edge.
- Response: occupancy stays 1 and c=9.
REQ-033 The bench SHALL cover counter wrap:
- Stimulus: 256 accepted transfers.
- Response: xfer_cnt returns to 0.
REQ-034 The bench SHALL cover reset mid-operation:
- Stimulus: all channels full, assert rst for one cycle.
- Response: out_valid=0000, a..d=0, xfer_cnt=0; the next in_valid to channel d is accepted immediately.
REQ-035 The bench SHALL cover pointer wrap:
- Stimulus: 20 words streamed through channel a with random out_ready.
- Response: output order matches input order; no loss or duplication.
